tx_fifo_sched: RTL and testbench
================================

# tx_fifo_sched

Transmit-side controller between the 4-entry TX FIFO and the UART transmitter core. Whenever transmission is enabled and the FIFO holds data, it pops one byte, hands it to the transmitter with a start pulse, and waits for completion. It then enforces a programmable inter-byte gap before the next byte. It also provides a FIFO flush, a completion watchdog and a transmitted-byte counter for the board status LEDs.

## Interface
- DATA_SIZE, 8, width of FIFO word and transmitter data
- GAP_CYCLES, 16, idle ckht cycles inserted after each completed byte; 0 means no gap
- TIMEOUT_CYCLES, 1_000_000, maximum ckht cycles spent waiting for tx_done_tick before abort; must be ≥ 1
- CNT_WIDTH, 16, width of byte_cnt
- ckht  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  level; 1 permits starting new bytes
- flush  in  1  single-cycle pulse; request to discard FIFO contents
- fifo_empty  in  1  FIFO empty flag (registered in the FIFO)
- fifo_rd_data  in  DATA_SIZE  FIFO head word (first-word fall-through, valid whenever fifo_empty=0)
- fifo_rd  out  1  FIFO pop strobe; one pop per high cycle
- tx_din  out  DATA_SIZE  registered byte presented to the transmitter
- tx_start  out  1  one-cycle start pulse to the transmitter
- tx_done_tick  in  1  one-cycle pulse from the transmitter at the end of the stop bit
- busy  out  1  1 whenever the state is not IDLE
- tx_err  out  1  sticky; set on watchdog timeout
- byte_cnt  out  CNT_WIDTH  count of completed bytes; wraps modulo 2^CNT_WIDTH

## Operation
- States: IDLE, LOAD, SEND, WAIT_DONE, GAP, FLUSH.
- flush_pend register:
  - Set by a flush pulse in any state.
  - Cleared on the transition IDLE→FLUSH.
- IDLE:
  - If flush_pend or flush is set → FLUSH. Flush has priority.
  - Else if enable=1 and fifo_empty=0 → LOAD.
- LOAD:
  - fifo_rd=1.
  - tx_din ← fifo_rd_data.
  - → SEND.
- SEND:
  - tx_start=1.
  - Load the watchdog with TIMEOUT_CYCLES.
  - → WAIT_DONE.
- WAIT_DONE:
  - On tx_done_tick: byte_cnt+1. Then → GAP with the gap counter loaded to GAP_CYCLES, or → IDLE if GAP_CYCLES=0.
  - Else decrement the watchdog. When it reaches 0: set tx_err, do not increment byte_cnt, → IDLE.
- GAP:
  - Decrement each cycle.
  - When the counter equals 1 → IDLE. The gap is exactly GAP_CYCLES cycles in GAP.
- FLUSH:
  - fifo_rd = ~fifo_empty. Pops one word per cycle.
  - Stay in FLUSH while fifo_empty=0. → IDLE on the first cycle fifo_empty=1.
  - tx_din and byte_cnt are unchanged.
- Outputs are decoded from the state only (Moore), except fifo_rd in FLUSH.
- tx_done_tick is ignored outside WAIT_DONE.
- enable=0 never aborts an in-flight byte. The current byte and its gap complete, then the block holds in IDLE.
- byte_cnt wraps: 16'hFFFF + 1 = 16'h0000.
- tx_err is cleared only by reset.

## Timing
- Reset values:
  - State IDLE, flush_pend=0.
  - fifo_rd=0, tx_start=0, tx_din=0, busy=0, tx_err=0, byte_cnt=0.
  - Gap and watchdog counters 0.
- Latency from IDLE start condition to tx_start:
  - Cycle N: IDLE samples fifo_empty=0 and enable=1.
  - Cycle N+1: fifo_rd=1.
  - Cycle N+2: tx_start=1, with tx_din already stable from N+2.
- tx_din is held constant from SEND until the next LOAD.
- Done to next start, for back-to-back bytes with GAP_CYCLES=G:
  - tx_done_tick at cycle M.
  - IDLE at M+G+1.
  - Next tx_start at M+G+3.
- Exactly one fifo_rd pulse per transmitted byte. A pop is never issued while fifo_empty=1.
- Flush pulse arriving while busy:
  - The current byte and gap complete first.
  - FLUSH is entered on the first IDLE cycle, with no new LOAD in between.
- Reset mid-operation (rst_n low in any state) returns immediately to reset values. Any transmitter activity is the transmitter's own concern.
- Watchdog: with no tx_done_tick, the block returns to IDLE exactly TIMEOUT_CYCLES+1 cycles after tx_start. tx_err is high from that return cycle.

## Structure
- Shared package uart_pkg holds:
  - The state enum tx_sched_state_t (IDLE, LOAD, SEND, WAIT_DONE, GAP, FLUSH).
  - Default constants TX_GAP_CYCLES_DEF and TX_TIMEOUT_DEF, used by the top level.
- One sub-module, down_timer (parameter MAX, ports load, dec, cnt, zero). It is instantiated twice: once for the gap and once for the watchdog.
- Counter widths are $clog2(MAX+1).

## Test plan
- Basic send: enable=1, GAP_CYCLES=4, FIFO preloaded with 8'hA5 → one fifo_rd pulse, tx_start 2 cycles later with tx_din=8'hA5. After tx_done_tick: byte_cnt=1, busy low 5 cycles after the tick.
- Burst: FIFO holds 8'h01..8'h04 → four tx_start pulses in order 01,02,03,04, each 3+GAP_CYCLES cycles after the previous tx_done_tick. byte_cnt=4, FIFO empty, busy=0.
- Enable gating: enable=0 with FIFO non-empty for 50 cycles → no fifo_rd and no tx_start. Drop enable mid-byte → the byte completes, then no further start.
- Flush: FIFO holds 3 words, flush pulse while busy on byte 1 → byte 1 completes. Then exactly 3 fifo_rd pulses in FLUSH, no tx_start, byte_cnt incremented by 1 only.
- Timeout: TIMEOUT_CYCLES=10, never assert tx_done_tick → tx_err=1 and state IDLE 11 cycles after tx_start. byte_cnt unchanged, next byte still sent.
- Reset/wrap: byte_cnt forced near 16'hFFFF by sending bytes, then wraps to 0. Assert rst_n=0 during WAIT_DONE → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and defaults: transmit scheduler
// state encoding, default gap/timeout, counter width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_DONE,
    GAP,
    FLUSH
  } tx_sched_state_t;

  localparam int TX_GAP_CYCLES_DEF = 16;
  localparam int TX_TIMEOUT_DEF    = 1_000_000;

  // A count of 0..max needs $clog2(max+1) bits; keep at least 1.
  function automatic int cnt_w(input int max);
    return (max > 0) ? $clog2(max + 1) : 1;
  endfunction

endpackage

// File: rtl/tx_fifo_sched_down_timer.sv
// down_timer: loadable down counter that saturates at zero.
// Ports: ckht/rst_n clock+async reset, load (cnt<=MAX), dec, cnt, zero.
module down_timer
  import uart_pkg::*;
#(
  parameter int MAX = 16,
  localparam int W  = cnt_w(MAX)
) (
  input  logic         ckht,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = W'(MAX);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge ckht or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/tx_fifo_sched.sv
// tx_fifo_sched: pops bytes from the TX FIFO into the UART transmitter
// with an inter-byte gap, flush, completion watchdog and byte counter.
// In:  ckht, rst_n, enable, flush, fifo_empty, fifo_rd_data, tx_done_tick
// Out: fifo_rd, tx_din, tx_start, busy, tx_err, byte_cnt
module tx_fifo_sched
  import uart_pkg::*;
#(
  parameter int DATA_SIZE      = 8,
  parameter int GAP_CYCLES     = TX_GAP_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TX_TIMEOUT_DEF,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 ckht,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 flush,
  input  logic                 fifo_empty,
  input  logic [DATA_SIZE-1:0] fifo_rd_data,
  output logic                 fifo_rd,
  output logic [DATA_SIZE-1:0] tx_din,
  output logic                 tx_start,
  input  logic                 tx_done_tick,
  output logic                 busy,
  output logic                 tx_err,
  output logic [CNT_WIDTH-1:0] byte_cnt
);

  localparam int GW = cnt_w(GAP_CYCLES);
  localparam int WW = cnt_w(TIMEOUT_CYCLES);

  tx_sched_state_t state_q, state_d;
  logic                 flush_pend_q, flush_pend_d;
  logic [DATA_SIZE-1:0] tx_din_q, tx_din_d;
  logic                 tx_err_q, tx_err_d;
  logic [CNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;

  logic [GW-1:0] gap_cnt;
  logic [WW-1:0] wd_cnt;
  logic gap_zero, wd_zero;
  logic gap_load, wd_load;
  logic gap_exp, wd_exp;

  assign gap_load = (state_q == WAIT_DONE) && tx_done_tick
                  && (GAP_CYCLES != 0);
  assign wd_load  = (state_q == SEND);

  down_timer #(.MAX(GAP_CYCLES)) u_gap (
    .ckht  (ckht),
    .rst_n (rst_n),
    .load  (gap_load),
    .dec   (state_q == GAP),
    .cnt   (gap_cnt),
    .zero  (gap_zero)
  );

  down_timer #(.MAX(TIMEOUT_CYCLES)) u_wd (
    .ckht  (ckht),
    .rst_n (rst_n),
    .load  (wd_load),
    .dec   (state_q == WAIT_DONE),
    .cnt   (wd_cnt),
    .zero  (wd_zero)
  );

  // Leave on the count-1 cycle so the dwell is exactly the loaded
  // value; zero is only a guard against ever stalling.
  assign gap_exp = (gap_cnt == GW'(1)) || gap_zero;
  assign wd_exp  = (wd_cnt == WW'(1)) || wd_zero;

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q | flush;
    tx_din_d     = tx_din_q;
    tx_err_d     = tx_err_q;
    byte_cnt_d   = byte_cnt_q;
    fifo_rd      = 1'b0;
    tx_start     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush_pend_q || flush) begin
          state_d      = FLUSH;
          flush_pend_d = 1'b0;
        end else if (enable && !fifo_empty) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        fifo_rd  = 1'b1;
        tx_din_d = fifo_rd_data;
        state_d  = SEND;
      end
      SEND: begin
        tx_start = 1'b1;
        state_d  = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done_tick) begin
          byte_cnt_d = byte_cnt_q + CNT_WIDTH'(1);
          state_d    = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else if (wd_exp) begin
          tx_err_d = 1'b1;
          state_d  = IDLE;
        end
      end
      GAP: begin
        if (gap_exp) begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        fifo_rd = ~fifo_empty;
        if (fifo_empty) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ckht or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      flush_pend_q <= 1'b0;
      tx_din_q     <= '0;
      tx_err_q     <= 1'b0;
      byte_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      tx_din_q     <= tx_din_d;
      tx_err_q     <= tx_err_d;
      byte_cnt_q   <= byte_cnt_d;
    end
  end

  assign tx_din   = tx_din_q;
  assign busy     = (state_q != IDLE);
  assign tx_err   = tx_err_q;
  assign byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_tx_fifo_sched.sv
// Directed bench for tx_fifo_sched with a 4-entry FIFO model
// and a hand-driven transmitter done tick.
module tb_tx_fifo_sched;

  localparam int G  = 4;
  localparam int T  = 10;
  localparam int CW = 4;

  logic          ckht = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic          tx_done_tick = 1'b0;
  logic          fifo_empty;
  logic [7:0]    fifo_rd_data;
  logic          fifo_rd;
  logic          tx_start;
  logic          busy;
  logic          tx_err;
  logic [7:0]    tx_din;
  logic [CW-1:0] byte_cnt;

  logic       push_v = 1'b0;
  logic [7:0] push_d = 8'h00;
  logic [7:0] mem [4];
  logic [1:0] wp = 2'd0;
  logic [1:0] rp = 2'd0;
  logic [2:0] fcnt = 3'd0;

  int pops = 0;
  int starts = 0;
  int bad_pops = 0;
  int total = 0;
  int bad = 0;

  always #5 ckht = ~ckht;

  tx_fifo_sched #(
    .DATA_SIZE      (8),
    .GAP_CYCLES     (G),
    .TIMEOUT_CYCLES (T),
    .CNT_WIDTH      (CW)
  ) dut (
    .ckht         (ckht),
    .rst_n        (rst_n),
    .enable       (enable),
    .flush        (flush),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd      (fifo_rd),
    .tx_din       (tx_din),
    .tx_start     (tx_start),
    .tx_done_tick (tx_done_tick),
    .busy         (busy),
    .tx_err       (tx_err),
    .byte_cnt     (byte_cnt)
  );

  assign fifo_empty   = (fcnt == 3'd0);
  assign fifo_rd_data = mem[rp];

  always @(posedge ckht) begin
    if (fifo_rd) begin
      pops <= pops + 1;
      if (fcnt == 3'd0) bad_pops <= bad_pops + 1;
      else rp <= rp + 2'd1;
    end
    if (tx_start) starts <= starts + 1;
    if (push_v) begin
      mem[wp] <= push_d;
      wp <= wp + 2'd1;
    end
    fcnt <= fcnt + 3'(push_v) - 3'(fifo_rd && (fcnt != 3'd0));
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge ckht);
  endtask

  task automatic push(input logic [7:0] d);
    push_d = d;
    push_v = 1'b1;
    step(1);
    push_v = 1'b0;
  endtask

  task automatic wait_start(input string tag, input logic [7:0] din,
                            output int n);
    n = 0;
    while (tx_start !== 1'b1 && n < 200) begin
      @(negedge ckht);
      n++;
    end
    chk({tag, "_start"}, 32'(tx_start), 32'd1);
    chk({tag, "_din"}, 32'(tx_din), 32'(din));
  endtask

  task automatic pulse_done(input int d);
    step(d);
    tx_done_tick = 1'b1;
    step(1);
    tx_done_tick = 1'b0;
  endtask

  initial begin
    int n, p0, s0;

    step(2);
    chk("rst_fifo_rd", 32'(fifo_rd), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_din", 32'(tx_din), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tx_err", 32'(tx_err), 0);
    chk("rst_byte_cnt", 32'(byte_cnt), 0);
    rst_n = 1'b1;
    step(1);

    // basic send
    push(8'hA5);
    p0 = pops;
    s0 = starts;
    enable = 1'b1;
    step(1);
    chk("basic_load_rd", 32'(fifo_rd), 1);
    chk("basic_load_start", 32'(tx_start), 0);
    chk("basic_load_din", 32'(tx_din), 0);
    step(1);
    chk("basic_send_start", 32'(tx_start), 1);
    chk("basic_send_din", 32'(tx_din), 32'hA5);
    chk("basic_send_rd", 32'(fifo_rd), 0);
    step(1);
    pulse_done(1);
    chk("basic_cnt", 32'(byte_cnt), 1);
    chk("basic_gap_busy", 32'(busy), 1);
    step(3);
    chk("basic_gap_end_busy", 32'(busy), 1);
    step(1);
    chk("basic_idle_busy", 32'(busy), 0);
    chk("basic_pops", pops - p0, 1);
    chk("basic_starts", starts - s0, 1);

    // burst of four
    enable = 1'b0;
    for (int i = 1; i <= 4; i++) push(8'(i));
    p0 = pops;
    s0 = starts;
    enable = 1'b1;
    wait_start("burst0", 8'h01, n);
    chk("burst0_lat", n, 2);
    for (int i = 1; i <= 3; i++) begin
      pulse_done(1);
      wait_start("burst", 8'(i + 1), n);
      chk("burst_gap", n, G + 2);
    end
    pulse_done(1);
    step(4);
    chk("burst_busy", 32'(busy), 0);
    chk("burst_cnt", 32'(byte_cnt), 5);
    chk("burst_empty", 32'(fifo_empty), 1);
    chk("burst_pops", pops - p0, 4);
    chk("burst_starts", starts - s0, 4);

    // enable gating
    enable = 1'b0;
    push(8'h11);
    push(8'h22);
    p0 = pops;
    s0 = starts;
    step(50);
    chk("gate_pops", pops - p0, 0);
    chk("gate_starts", starts - s0, 0);
    chk("gate_busy", 32'(busy), 0);
    enable = 1'b1;
    wait_start("gate", 8'h11, n);
    enable = 1'b0;
    pulse_done(3);
    step(4);
    chk("gate_idle", 32'(busy), 0);
    step(20);
    chk("gate_starts2", starts - s0, 1);
    chk("gate_pops2", pops - p0, 1);
    chk("gate_cnt", 32'(byte_cnt), 6);
    chk("gate_fifo", 32'(fifo_empty), 0);

    // flush while busy
    push(8'h33);
    push(8'h44);
    push(8'h55);
    p0 = pops;
    s0 = starts;
    enable = 1'b1;
    wait_start("flush", 8'h22, n);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    pulse_done(1);
    step(5);
    chk("flush_rd", 32'(fifo_rd), 1);
    chk("flush_no_start", 32'(tx_start), 0);
    step(3);
    chk("flush_last_rd", 32'(fifo_rd), 0);
    chk("flush_busy", 32'(busy), 1);
    chk("flush_empty", 32'(fifo_empty), 1);
    step(1);
    chk("flush_idle", 32'(busy), 0);
    step(10);
    chk("flush_pops", pops - p0, 4);
    chk("flush_starts", starts - s0, 1);
    chk("flush_cnt", 32'(byte_cnt), 7);

    // watchdog timeout
    enable = 1'b0;
    push(8'h66);
    push(8'h77);
    enable = 1'b1;
    wait_start("to", 8'h66, n);
    step(T);
    chk("to_wait_busy", 32'(busy), 1);
    chk("to_wait_err", 32'(tx_err), 0);
    step(1);
    chk("to_busy", 32'(busy), 0);
    chk("to_err", 32'(tx_err), 1);
    chk("to_cnt", 32'(byte_cnt), 7);
    wait_start("to_next", 8'h77, n);
    chk("to_next_lat", n, 2);
    pulse_done(1);
    chk("to_next_cnt", 32'(byte_cnt), 8);
    chk("to_err_sticky", 32'(tx_err), 1);

    // counter wrap at 2^CW
    for (int i = 0; i < 8; i++) begin
      push(8'(192 + i));
      wait_start("wrap", 8'(192 + i), n);
      pulse_done(1);
      chk("wrap_cnt", 32'(byte_cnt), 32'((9 + i) % 16));
    end

    // asynchronous reset during WAIT_DONE
    step(4);
    push(8'h88);
    wait_start("rst", 8'h88, n);
    step(2);
    chk("pre_rst_busy", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_fifo_rd", 32'(fifo_rd), 0);
    chk("arst_tx_start", 32'(tx_start), 0);
    chk("arst_tx_din", 32'(tx_din), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_tx_err", 32'(tx_err), 0);
    chk("arst_byte_cnt", 32'(byte_cnt), 0);
    @(negedge ckht);
    rst_n = 1'b1;
    step(3);
    chk("post_rst_busy", 32'(busy), 0);
    chk("no_empty_pop", bad_pops, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
